// File: rtl/ascii_key_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module  : ascii_key_fifo_if
//  Brief   : Keystroke FIFO bus: decoder write side and PicoBlaze read side.
//  Revision: 1.0 - initial release
// ============================================================================
interface ascii_key_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              interrupt_ack;
    logic              clr_overflow;
    logic [DATA_W-1:0] rd_data;
    logic              interrupt;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              overflow;

    modport master (
        output wr_en, wr_data, interrupt_ack, clr_overflow,
        input  rd_data, interrupt, count, full, overflow
    );

    modport slave (
        input  wr_en, wr_data, interrupt_ack, clr_overflow,
        output rd_data, interrupt, count, full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ascii_key_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : ascii_key_fifo
//  Brief   : DEPTH-entry keystroke FIFO driving the PicoBlaze interrupt level.
//            Define ASCII_KEY_FIFO_REPEAT_FILTER_EN for typematic suppression.
//  Revision: 1.0 - initial release
// ============================================================================
module ascii_key_fifo #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HOLDOFF_CYC = 5000000
) (
    input  wire              clk,
    input  wire              Reset,
    ascii_key_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);

    if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || HOLDOFF_CYC < 1) begin : g_param_check
        $error("ascii_key_fifo: DEPTH must be 2**ADDR_W, >= 2; HOLDOFF_CYC >= 1");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic w_filt;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    assign w_pop  = bus.interrupt_ack && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr   = bus.wr_en && !w_filt && ((r_count != c_DEPTH) || w_pop);
    assign w_drop = bus.wr_en && !w_filt && !w_wr;

`ifdef ASCII_KEY_FIFO_REPEAT_FILTER_EN
    localparam int                 c_HOLD_W = $clog2(HOLDOFF_CYC + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD  = c_HOLD_W'(HOLDOFF_CYC);

    logic [DATA_W-1:0]   r_last_code;
    logic [c_HOLD_W-1:0] r_holdoff;

    assign w_filt = bus.wr_en && (bus.wr_data == r_last_code) && (r_holdoff != '0);

    // Every wr_en, repeated or not, restarts the holdoff window.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_last_code <= '0;
            r_holdoff   <= '0;
        end else if (bus.wr_en) begin
            r_last_code <= bus.wr_data;
            r_holdoff   <= c_HOLD;
        end else if (r_holdoff != '0) begin
            r_holdoff   <= r_holdoff - 1'b1;
        end
    end
`else
    assign w_filt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.rd_data   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign bus.interrupt = (r_count != '0);
    assign bus.count     = r_count;
    assign bus.full      = (r_count == c_DEPTH);
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_ascii_key_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ascii_key_fifo
//  Brief   : Directed bench for ascii_key_fifo with a queue reference model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ascii_key_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int HOLD  = 20;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    ascii_key_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ascii_key_fifo #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .HOLDOFF_CYC(HOLD)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored codes plus a sticky overflow bit
    logic [DW-1:0] mq[$];
    bit            m_valid = 0;
    bit            m_ovf;
    bit            m_seen;
    logic [DW-1:0] m_last;
    longint        m_last_cyc;
    longint        cyc = 0;
    bit            m_pop, m_filt, m_acc;

    always @(posedge clk) begin
        cyc++;
        if (!Reset) begin
            mq.delete();
            m_ovf   = 0;
            m_seen  = 0;
            m_last  = '0;
            m_valid = 1;
        end else begin
            m_pop  = bus.interrupt_ack && (mq.size() != 0);
            m_filt = 0;
`ifdef ASCII_KEY_FIFO_REPEAT_FILTER_EN
            m_filt = bus.wr_en && m_seen && (bus.wr_data == m_last)
                     && ((cyc - m_last_cyc) <= HOLD);
            if (bus.wr_en) begin
                m_seen     = 1;
                m_last     = bus.wr_data;
                m_last_cyc = cyc;
            end
`endif
            m_acc = bus.wr_en && !m_filt && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(bus.wr_data);
            if (bus.wr_en && !m_filt && !m_acc) m_ovf = 1;
            else if (bus.clr_overflow)           m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_rd_data",   32'(bus.rd_data),   (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            chk("m_interrupt", 32'(bus.interrupt), 32'(mq.size() != 0));
            chk("m_count",     32'(bus.count),     32'(mq.size()));
            chk("m_full",      32'(bus.full),      32'(mq.size() == DEPTH));
            chk("m_overflow",  32'(bus.overflow),  32'(m_ovf));
        end
    end

    task automatic step(input logic w, input logic [DW-1:0] d, input logic a, input logic c);
        bus.wr_en         = w;
        bus.wr_data       = d;
        bus.interrupt_ack = a;
        bus.clr_overflow  = c;
        @(posedge clk);
        #1;
        bus.wr_en         = 1'b0;
        bus.interrupt_ack = 1'b0;
        bus.clr_overflow  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain(input string nm, input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            chk(nm, 32'(bus.rd_data), 32'(first + DW'(i)));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk({nm, "_empty"}, 32'(bus.count), 32'd0);
    endtask

    initial begin
        Reset             = 1'b0;
        bus.wr_en         = 1'b1;
        bus.wr_data       = 8'h99;
        bus.interrupt_ack = 1'b0;
        bus.clr_overflow  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_count", 32'(bus.count),     32'd0);
            chk("rst_int",   32'(bus.interrupt), 32'd0);
            chk("rst_rd",    32'(bus.rd_data),   32'd0);
            chk("rst_ovf",   32'(bus.overflow),  32'd0);
        end
        bus.wr_en = 1'b0;
        Reset     = 1'b1;

        // Single key
        step(1'b1, 8'h41, 1'b0, 1'b0);
        chk("single_int", 32'(bus.interrupt), 32'd1);
        chk("single_rd",  32'(bus.rd_data),   32'h41);
        idle(4);
        chk("single_hold", 32'(bus.rd_data), 32'h41);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_int0", 32'(bus.interrupt), 32'd0);
        chk("single_cnt0", 32'(bus.count),     32'd0);

        // Fill, overflow, clear, drain, then second fill across the wrap
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b1, 8'h7A, 1'b0, 1'b0);
        chk("fill_full",  32'(bus.full),     32'd1);
        chk("fill_count", 32'(bus.count),    32'd16);
        chk("fill_ovf",   32'(bus.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        drain("drain1", 8'h30, 16);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        chk("wrap_full", 32'(bus.full), 32'd1);
        drain("drain2", 8'h50, 16);

        // Simultaneous write + ack, empty then full
        step(1'b1, 8'h21, 1'b1, 1'b0);
        chk("sim_e_count", 32'(bus.count),   32'd1);
        chk("sim_e_rd",    32'(bus.rd_data), 32'h21);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h70, 1'b1, 1'b0);
        chk("sim_f_count", 32'(bus.count),    32'd16);
        chk("sim_f_ovf",   32'(bus.overflow), 32'd0);
        drain("drain3", 8'h61, 16);

        // Reset mid-operation
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        Reset = 1'b0;
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        Reset = 1'b1;
        chk("mid_rst_count", 32'(bus.count),     32'd0);
        chk("mid_rst_int",   32'(bus.interrupt), 32'd0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("mid_rst_rd", 32'(bus.rd_data), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Typematic repeats
        step(1'b1, 8'h61, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 8'h61, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 8'h61, 1'b0, 1'b0);
        idle(30);
        step(1'b1, 8'h61, 1'b0, 1'b0);
`ifdef ASCII_KEY_FIFO_REPEAT_FILTER_EN
        chk("filt_count", 32'(bus.count), 32'd2);
        for (int i = 0; i < 2; i++) begin
            chk("filt_rd", 32'(bus.rd_data), 32'h61);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
`else
        chk("filt_count", 32'(bus.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("filt_rd", 32'(bus.rd_data), 32'h61);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
`endif
        chk("final_empty", 32'(bus.interrupt), 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ascii_key_fifo.md
Name: ascii_key_fifo

Overview:
- Parametrised keystroke buffer between the PS/2 keyboard/ASCII decoder and the PicoBlaze input port.
- Replaces the single-entry "latch on interrupt" ASCII register with a DEPTH-entry FIFO.
- Holds the processor interrupt high while data is pending and pops one entry per interrupt acknowledge, so bursts of keys are not lost while the processor is busy.
- Overflow is tracked and optional typematic-repeat suppression is available.

Parameters:
DATA_W, 8, width of each stored code (ASCII byte)
DEPTH, 16, number of FIFO entries; power of two, ≥2
ADDR_W, 4, pointer width, must equal log2(DEPTH)
HOLDOFF_CYC, 5000000, repeat-suppression window in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous active-low reset
wr_en  input  1  one-cycle strobe from keyboard decoder: new code valid
wr_data  input  DATA_W  code accompanying wr_en
interrupt_ack  input  1  one-cycle acknowledge from PicoBlaze; pops head entry
clr_overflow  input  1  one-cycle strobe; clears overflow flag
rd_data  output  DATA_W  head-of-FIFO code (feeds PicoBlaze in_port)
interrupt  output  1  high while FIFO non-empty
count  output  ADDR_W+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky: a write was dropped because FIFO was full

Behaviour:
- Reset: sampled at posedge clk when Reset==0. wr_ptr=0, rd_ptr=0, count=0, interrupt=0, full=0, overflow=0, rd_data=0. Storage contents need not be cleared. Reset overrides all other inputs in the same cycle, including mid-burst.
- Storage: register array of DEPTH x DATA_W. Write at wr_ptr; rd_data = mem[rd_ptr] when count≠0, else 0.
- Write accept: wr_en=1 and (count<DEPTH or pop this cycle). Store wr_data at wr_ptr. wr_ptr increments and wraps DEPTH-1 -> 0.
- Pop accept: interrupt_ack=1 and count≠0. rd_ptr increments and wraps DEPTH-1 -> 0.
- Count update:
  - write only: +1
  - pop only: -1
  - both: unchanged
- Latency: a write to an empty FIFO at edge N gives interrupt=1 and rd_data=wr_data after edge N (visible in cycle N+1). After a pop at edge N, rd_data shows the next entry from cycle N+1; interrupt falls in cycle N+1 if count reaches 0.
- Boundary cases:
  - Empty + ack, no write: ignored. No pointer move, no error.
  - Empty + simultaneous write + ack: write accepted, ack ignored, count=1.
  - Full + write, no ack: write dropped, overflow<=1, contents unchanged.
  - Full + simultaneous write + ack: both accepted, count stays DEPTH, overflow unchanged.
  - Overflow: set by a dropped write; cleared only by clr_overflow or reset. If clr_overflow and a dropped write occur in the same cycle, set wins.
- interrupt is a level (combinational from count≠0, or registered with identical timing). The processor handler reads rd_data before pulsing interrupt_ack.
- interrupt_ack held high for multiple cycles pops one entry per cycle; upstream is required to pulse it for one cycle.

Optional Feature:
- Macro: ASCII_KEY_FIFO_REPEAT_FILTER_EN
- Defined:
  - Block keeps last_code (DATA_W) and a holdoff counter (≥ log2(HOLDOFF_CYC) bits).
  - A wr_en with wr_data==last_code while the counter is nonzero is discarded: no store, no overflow effect, counter reloaded to HOLDOFF_CYC.
  - Any other accepted-or-dropped wr_en updates last_code and reloads the counter.
  - The counter decrements to 0 each cycle.
  - Reset clears last_code to 0 and the counter to 0.
- Not defined: every wr_en is processed as above; no extra registers exist.

Test Plan:
- Reset: hold Reset=0 for 3 cycles with wr_en=1 -> count=0, interrupt=0, rd_data=0, overflow=0 throughout.
- Single key: write 0x41, wait 4 cycles, pulse ack -> interrupt=1 and rd_data=0x41 from the cycle after the write; interrupt=0 and count=0 the cycle after ack.
- Fill/overflow (DEPTH=16): write 0x30..0x3F, then 0x7A -> full=1, count=16, overflow=1, 0x7A lost. Clear with clr_overflow, then 16 acks -> reads 0x30..0x3F in order; pointers wrap on a second fill of 0x50..0x5F.
- Simultaneous events: write+ack when empty -> count=1, rd_data=new byte. Write+ack when full -> count=16, overflow stays 0, new byte appears as the last of 16 reads.
- Reset mid-operation: 5 entries queued, Reset=0 one cycle -> count=0, interrupt=0; next write 0x55 is read first.
- Filter (macro defined, HOLDOFF_CYC=20): write 0x61 three times 5 cycles apart, then again 30 cycles after the last -> count=2, entries 0x61, 0x61. Macro undefined -> count=4.
